// File: rtl/rule_scheduler_if.sv
// Signal bundle between the round-robin rule scheduler and the guarded system.
// The master side is the scheduler; the slave side is the system/bench.
interface rule_scheduler_if #(
    parameter int NUM_RULES = 7,
    parameter int W         = 3
);
    logic [NUM_RULES-1:0] io_guard;
    logic                 io_hold;
    logic [W-1:0]         io_en_a;
    logic                 io_fired;
    logic                 io_starved;
    logic                 io_deadlock;
    logic [15:0]          io_fire_count;

    modport master (
        input  io_guard, io_hold,
        output io_en_a, io_fired, io_starved,
        output io_deadlock, io_fire_count
    );

    modport slave (
        output io_guard, io_hold,
        input  io_en_a, io_fired, io_starved,
        input  io_deadlock, io_fire_count
    );
endinterface

// File: rtl/rule_scheduler.sv
// Round-robin scheduler: SELECT samples guards, FIRE presents one rule code.
// Also raises sticky starvation and deadlock flags for fault detection.
module rule_scheduler #(
    parameter int NUM_RULES      = 7,
    parameter int W              = 3,
    parameter int STARVE_LIMIT   = 8,
    parameter int DEADLOCK_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    rule_scheduler_if.master  bus
);
    localparam int PW = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int DW = $clog2(DEADLOCK_LIMIT + 1);

    typedef enum logic {SELECT, FIRE} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [W-1:0]    code_q, code_d;
    logic [SW-1:0]   skip_q [NUM_RULES];
    logic [SW-1:0]   skip_d [NUM_RULES];
    logic [DW-1:0]   dl_q, dl_d;
    logic            starved_q, starved_d;
    logic            deadlock_q, deadlock_d;
    logic [15:0]     count_q, count_d;

    logic            found;
    logic [PW-1:0]   sel;
    logic [PW-1:0]   idx;
    int              idx_i;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        code_d     = code_q;
        skip_d     = skip_q;
        dl_d       = dl_q;
        starved_d  = starved_q;
        deadlock_d = deadlock_q;
        count_d    = count_q;
        found      = 1'b0;
        sel        = '0;
        idx        = '0;
        idx_i      = 0;

        // Circular search starting at ptr; first set guard wins.
        for (int k = 0; k < NUM_RULES; k++) begin
            idx_i = int'(ptr_q) + k;
            if (idx_i >= NUM_RULES) idx_i = idx_i - NUM_RULES;
            idx = PW'(idx_i);
            if (!found && bus.io_guard[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end

        case (state_q)
            SELECT: begin
                if (!bus.io_hold) begin
                    state_d = FIRE;
                    if (found) begin
                        code_d = W'(sel) + 1'b1;
                        ptr_d  = (int'(sel) == NUM_RULES - 1) ?
                                 '0 : sel + 1'b1;
                    end else begin
                        code_d = '0;
                    end
                    for (int i = 0; i < NUM_RULES; i++) begin
                        if (found && sel == PW'(i)) begin
                            skip_d[i] = '0;
                        end else if (!bus.io_guard[i]) begin
                            skip_d[i] = '0;
                        end else if (skip_q[i] != SW'(STARVE_LIMIT)) begin
                            skip_d[i] = skip_q[i] + 1'b1;
                        end
                        if (skip_d[i] >= SW'(STARVE_LIMIT))
                            starved_d = 1'b1;
                    end
                    if (bus.io_guard == '0) begin
                        if (dl_q != DW'(DEADLOCK_LIMIT))
                            dl_d = dl_q + 1'b1;
                    end else begin
                        dl_d = '0;
                    end
                    if (dl_d >= DW'(DEADLOCK_LIMIT))
                        deadlock_d = 1'b1;
                end
            end
            FIRE: begin
                if (code_q != '0 && count_q != 16'hFFFF)
                    count_d = count_q + 16'd1;
                state_d = SELECT;
            end
            default: state_d = SELECT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= SELECT;
            ptr_q      <= '0;
            code_q     <= '0;
            dl_q       <= '0;
            starved_q  <= 1'b0;
            deadlock_q <= 1'b0;
            count_q    <= '0;
            for (int i = 0; i < NUM_RULES; i++) skip_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            code_q     <= code_d;
            dl_q       <= dl_d;
            starved_q  <= starved_d;
            deadlock_q <= deadlock_d;
            count_q    <= count_d;
            for (int i = 0; i < NUM_RULES; i++) skip_q[i] <= skip_d[i];
        end
    end

    assign bus.io_en_a       = (state_q == FIRE) ? code_q : '0;
    assign bus.io_fired      = (state_q == FIRE) && (code_q != '0);
    assign bus.io_starved    = starved_q;
    assign bus.io_deadlock   = deadlock_q;
    assign bus.io_fire_count = count_q;
endmodule

// File: tb/tb_rule_scheduler.sv
// Scoreboard bench: a spec model predicts each fired code at SELECT time,
// and the prediction is popped and compared when the FIRE cycle appears.
module tb_rule_scheduler;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    rule_scheduler_if #(.NUM_RULES(7), .W(3)) bus ();
    rule_scheduler_if #(.NUM_RULES(7), .W(3)) bus2 ();

    assign bus2.io_guard = bus.io_guard;
    assign bus2.io_hold  = bus.io_hold;

    rule_scheduler #(.NUM_RULES(7), .W(3), .STARVE_LIMIT(8),
                     .DEADLOCK_LIMIT(4))
        dut (.clock(clock), .reset(reset), .bus(bus));

    rule_scheduler #(.NUM_RULES(7), .W(3), .STARVE_LIMIT(2),
                     .DEADLOCK_LIMIT(4))
        dut2 (.clock(clock), .reset(reset), .bus(bus2));

    int n_chk = 0;
    int n_err = 0;

    bit         m_fire;
    int         m_ptr;
    logic [2:0] m_code;
    int         m_skip [7];
    int         m_dlc;
    bit         m_st, m_st2, m_dl;
    int         m_cnt;
    logic [2:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fire = 1'b0;
        m_ptr  = 0;
        m_code = '0;
        m_dlc  = 0;
        m_st   = 1'b0;
        m_st2  = 1'b0;
        m_dl   = 1'b0;
        m_cnt  = 0;
        for (int i = 0; i < 7; i++) m_skip[i] = 0;
        exp_q.delete();
    endtask

    task automatic check_now();
        logic [2:0] exp_en;
        exp_en = '0;
        if (m_fire) begin
            if (exp_q.size() == 0) check("queue_empty", 32'd1, 32'd0);
            else exp_en = exp_q.pop_front();
        end
        check("en_a", 32'(bus.io_en_a), 32'(exp_en));
        check("fired", 32'(bus.io_fired), 32'(exp_en != 3'd0));
        check("fire_count", 32'(bus.io_fire_count), 32'(m_cnt));
        check("deadlock", 32'(bus.io_deadlock), 32'(m_dl));
        check("starved", 32'(bus.io_starved), 32'(m_st));
        check("starved_lim2", 32'(bus2.io_starved), 32'(m_st2));
    endtask

    task automatic advance(input logic [6:0] g, input logic h);
        int j;
        int idx;
        if (m_fire) begin
            if (m_code != 3'd0 && m_cnt < 16'hFFFF) m_cnt++;
            m_fire = 1'b0;
        end else if (!h) begin
            j = -1;
            for (int k = 0; k < 7; k++) begin
                idx = (m_ptr + k) % 7;
                if (j < 0 && g[idx[2:0]]) j = idx;
            end
            m_code = (j < 0) ? 3'd0 : 3'(j + 1);
            if (j >= 0) m_ptr = (j + 1) % 7;
            exp_q.push_back(m_code);
            for (int i = 0; i < 7; i++) begin
                if (i == j || !g[i]) m_skip[i] = 0;
                else m_skip[i]++;
                if (m_skip[i] >= 8) m_st = 1'b1;
                if (m_skip[i] >= 2) m_st2 = 1'b1;
            end
            if (g == 7'd0) m_dlc++;
            else m_dlc = 0;
            if (m_dlc >= 4) m_dl = 1'b1;
            m_fire = 1'b1;
        end
    endtask

    task automatic cycle(input logic [6:0] g, input logic h);
        check_now();
        bus.io_guard = g;
        bus.io_hold  = h;
        advance(g, h);
        @(negedge clock);
    endtask

    task automatic do_reset(input bit chk_first);
        if (chk_first) check_now();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        bus.io_guard = '0;
        bus.io_hold  = 1'b0;
        model_reset();
        @(negedge clock);
        do_reset(1'b0);

        repeat (6) cycle(7'h01, 1'b0);
        do_reset(1'b1);

        repeat (16) cycle(7'h7F, 1'b0);
        repeat (8) cycle(7'h00, 1'b0);
        repeat (4) cycle(7'h7F, 1'b0);
        do_reset(1'b1);

        repeat (4) cycle(7'h7F, 1'b0);
        repeat (5) cycle(7'h7F, 1'b1);
        cycle(7'h7F, 1'b0);
        do_reset(1'b1);
        repeat (4) cycle(7'h7F, 1'b0);

        repeat (80) cycle(7'($urandom), ($urandom_range(0, 3) == 0));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
